// File: rtl/cnn_pkg.sv
// Shared defaults and helpers for the CNN row streaming blocks.
// Row geometry helpers let every block size its buffers from the same parameters.
package cnn_pkg;

  localparam int DEF_VALUE_BITS  = 8;
  localparam int DEF_WIDTH       = 28;
  localparam int DEF_HEIGHT      = 28;
  localparam int DEF_IN_CHANNELS = 1;

  function automatic int row_words(input int width, input int channels);
    return width * channels;
  endfunction

  function automatic int row_bits(input int width, input int channels, input int value_bits);
    return row_words(width, channels) * value_bits;
  endfunction

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ROW_WORDS = row_words(DEF_WIDTH, DEF_IN_CHANNELS);

  typedef logic [DEF_WIDTH-1:0][DEF_IN_CHANNELS-1:0][DEF_VALUE_BITS-1:0] row_t;

  typedef enum logic {
    ROW_EMPTY = 1'b0,
    ROW_FULL  = 1'b1
  } row_state_e;

endpackage

// File: rtl/cnn_row_reg.sv
// One buffered row slot: row payload, its last-of-image flag and an EMPTY/FULL state.
// Load wins over clear so a slot can be refilled in the same cycle it is drained.
module cnn_row_reg
  import cnn_pkg::*;
#(
  parameter int ROW_BITS = 8
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                load,
  input  logic                clear,
  input  logic [ROW_BITS-1:0] next_row,
  input  logic                next_last,
  output logic [ROW_BITS-1:0] row,
  output logic                last,
  output logic                valid
);

  row_state_e          state_q, state_d;
  logic [ROW_BITS-1:0] row_q;
  logic                last_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ROW_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ROW_FULL;
    end else if (clear) begin
      state_d = ROW_EMPTY;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      row_q  <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      row_q  <= next_row;
      last_q <= next_last;
    end
  end

  assign row   = row_q;
  assign last  = last_q;
  assign valid = (state_q == ROW_FULL);

endmodule

// File: rtl/cnn_row_source.sv
// Packs a serial pixel word stream into image rows and offers them with valid/last.
// A fill slot behind the output slot keeps the input flowing while a row awaits acceptance.
module cnn_row_source
  import cnn_pkg::*;
#(
  parameter int VALUE_BITS  = DEF_VALUE_BITS,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int IN_CHANNELS = DEF_IN_CHANNELS
) (
  input  logic                                               clock_i,
  input  logic                                               reset_i,
  input  logic [31:0]                                        in_data_i,
  input  logic                                               in_valid_i,
  output logic                                               upstream_stall_o,
  output logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0]  row_o,
  output logic                                               row_valid_o,
  output logic                                               row_last_o,
  input  logic                                               row_accept_i
);

  localparam int ROW_BITS = row_bits(WIDTH, IN_CHANNELS, VALUE_BITS);
  localparam int XW       = idx_bits(WIDTH);
  localparam int CW       = idx_bits(IN_CHANNELS);
  localparam int RW       = idx_bits(HEIGHT);

  typedef logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0] row_buf_t;

  logic [XW-1:0]       x_q;
  logic [CW-1:0]       ch_q;
  logic [RW-1:0]       row_idx_q;
  row_buf_t            acc_q;
  row_buf_t            completed;

  logic                word_take;
  logic                word_final;
  logic                row_xfer;
  logic                row_done_last;
  logic                fill_full;
  logic                out_valid;

  logic                out_load;
  logic                out_clear;
  logic [ROW_BITS-1:0] out_next_row;
  logic                out_next_last;
  logic [ROW_BITS-1:0] out_row;
  logic                out_last;

  logic                fill_load;
  logic                fill_clear;
  logic [ROW_BITS-1:0] fill_row;
  logic                fill_last;

  if (VALUE_BITS < 32) begin : g_upper
    logic unused_upper;
    assign unused_upper = ^in_data_i[31:VALUE_BITS];
  end

  assign word_take     = in_valid_i && !fill_full;
  assign word_final    = word_take && (x_q == XW'(WIDTH - 1)) && (ch_q == CW'(IN_CHANNELS - 1));
  assign row_xfer      = out_valid && row_accept_i;
  assign row_done_last = (row_idx_q == RW'(HEIGHT - 1));

  // The row being finished this cycle: everything gathered so far plus the incoming word.
  always_comb begin
    completed             = acc_q;
    completed[x_q][ch_q]  = in_data_i[VALUE_BITS-1:0];
  end

  // Word k lands at x = k mod WIDTH, channel = k / WIDTH; all of channel 0 arrives first.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      x_q   <= '0;
      ch_q  <= '0;
      acc_q <= '0;
    end else if (word_take) begin
      acc_q <= completed;
      if (x_q == XW'(WIDTH - 1)) begin
        x_q  <= '0;
        ch_q <= (ch_q == CW'(IN_CHANNELS - 1)) ? '0 : ch_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // Rows reach the output strictly in completion order, so indexing at completion tags them correctly.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      row_idx_q <= '0;
    end else if (word_final) begin
      row_idx_q <= row_done_last ? '0 : row_idx_q + 1'b1;
    end
  end

  always_comb begin
    out_load      = 1'b0;
    out_clear     = 1'b0;
    out_next_row  = completed;
    out_next_last = row_done_last;
    fill_load     = 1'b0;
    fill_clear    = 1'b0;
    if (fill_full && row_xfer) begin
      out_load      = 1'b1;
      out_next_row  = fill_row;
      out_next_last = fill_last;
      fill_clear    = 1'b1;
    end else if (word_final && (!out_valid || row_xfer)) begin
      out_load = 1'b1;
    end else if (word_final) begin
      fill_load = 1'b1;
    end else if (row_xfer) begin
      out_clear = 1'b1;
    end
  end

  cnn_row_reg #(
    .ROW_BITS (ROW_BITS)
  ) u_fill (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .load      (fill_load),
    .clear     (fill_clear),
    .next_row  (completed),
    .next_last (row_done_last),
    .row       (fill_row),
    .last      (fill_last),
    .valid     (fill_full)
  );

  cnn_row_reg #(
    .ROW_BITS (ROW_BITS)
  ) u_out (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .load      (out_load),
    .clear     (out_clear),
    .next_row  (out_next_row),
    .next_last (out_next_last),
    .row       (out_row),
    .last      (out_last),
    .valid     (out_valid)
  );

  assign row_o            = out_row;
  assign row_valid_o      = out_valid;
  assign row_last_o       = out_last;
  assign upstream_stall_o = fill_full;

endmodule

// File: tb/tb_cnn_row_source.sv
// Directed bench for cnn_row_source with a row scoreboard fed by the words it drives.
module tb_cnn_row_source;

  localparam int VB = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int C  = 2;
  localparam int N  = W * C;

  typedef logic [W-1:0][C-1:0][VB-1:0] trow_t;
  typedef struct {
    trow_t row;
    logic  last;
  } exp_t;

  logic        clock_i      = 1'b0;
  logic        reset_i      = 1'b1;
  logic [31:0] in_data_i    = '0;
  logic        in_valid_i   = 1'b0;
  logic        row_accept_i = 1'b0;
  logic        upstream_stall_o;
  logic        row_valid_o;
  logic        row_last_o;
  trow_t       row_o;

  int    total   = 0;
  int    bad     = 0;
  exp_t  sb[$];
  trow_t partial = '0;
  int    word_k  = 0;
  int    img_row = 0;
  logic  took;

  always #5 clock_i = ~clock_i;

  cnn_row_source #(
    .VALUE_BITS  (VB),
    .WIDTH       (W),
    .HEIGHT      (H),
    .IN_CHANNELS (C)
  ) dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .in_data_i        (in_data_i),
    .in_valid_i       (in_valid_i),
    .upstream_stall_o (upstream_stall_o),
    .row_o            (row_o),
    .row_valid_o      (row_valid_o),
    .row_last_o       (row_last_o),
    .row_accept_i     (row_accept_i)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard holds rows completed but not yet taken: head is on row_o, a second one means stall.
  task automatic checkModel(input string tag);
    checkOutput({tag, ".valid"}, 64'(row_valid_o), 64'(sb.size() > 0));
    checkOutput({tag, ".stall"}, 64'(upstream_stall_o), 64'(sb.size() == 2));
    if (sb.size() > 0) begin
      checkOutput({tag, ".row"}, row_o, sb[0].row);
      checkOutput({tag, ".last"}, 64'(row_last_o), 64'(sb[0].last));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic [31:0] d,
                               input logic a, output logic accepted);
    logic xfer;
    in_valid_i   = v;
    in_data_i    = d;
    row_accept_i = a;
    checkModel(tag);
    xfer     = (sb.size() > 0) && a;
    accepted = v && (sb.size() != 2);
    @(posedge clock_i);
    #1;
    if (xfer) void'(sb.pop_front());
    if (accepted) begin
      partial[word_k % W][word_k / W] = d[VB-1:0];
      word_k++;
      if (word_k == N) begin
        sb.push_back('{row: partial, last: (img_row == H - 1)});
        img_row = (img_row + 1) % H;
        word_k  = 0;
      end
    end
  endtask

  task automatic streamWords(input string tag, input logic [31:0] base, input int count,
                             input logic a, input bit toggle);
    int   sent = 0;
    int   cyc  = 0;
    logic acc;
    logic v;
    while (sent < count && cyc < 200) begin
      v = toggle ? ((cyc % 2) == 0) : 1'b1;
      applyStimulus(tag, v, base + 32'(sent), a, acc);
      if (acc) sent++;
      cyc++;
    end
    total++;
    assert (sent == count) else begin
      bad++;
      $error("[TB] FAIL %s.timeout observed=%0d expected=%0d", tag, sent, count);
    end
  endtask

  task automatic idle(input string tag, input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) applyStimulus(tag, 1'b0, 32'h0, 1'b1, acc);
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clock_i);
    #1;
    checkOutput("reset.valid", 64'(row_valid_o), 64'h0);
    checkOutput("reset.stall", 64'(upstream_stall_o), 64'h0);
    checkOutput("reset.row", row_o, 64'h0);
    checkOutput("reset.last", 64'(row_last_o), 64'h0);
    reset_i = 1'b0;
    @(posedge clock_i);
    #1;

    // First row, consumer always ready.
    streamWords("row0", 32'h10, N, 1'b1, 1'b0);
    checkOutput("row0.valid_const", 64'(row_valid_o), 64'h1);
    checkOutput("row0.row_const", row_o, 64'h1713_1612_1511_1410);
    checkOutput("row0.last_const", 64'(row_last_o), 64'h0);

    // Three more rows back to back: image row indices 1, 2, then wrap to 0.
    streamWords("b2b", 32'h20, 3 * N, 1'b1, 1'b0);
    idle("b2b_drain", 2);

    // Consumer stalled: second row parks in the fill slot and the input stalls.
    streamWords("hold", 32'h40, 2 * N, 1'b0, 1'b0);
    checkOutput("hold.stall_const", 64'(upstream_stall_o), 64'h1);
    applyStimulus("hold_w16", 1'b1, 32'h50, 1'b0, took);
    checkOutput("hold_w16.not_taken", 64'(took), 64'h0);
    applyStimulus("accept_w16", 1'b1, 32'h50, 1'b1, took);
    checkOutput("accept_w16.not_taken", 64'(took), 64'h0);
    checkOutput("accept.stall_drop", 64'(upstream_stall_o), 64'h0);
    applyStimulus("resume_w16", 1'b1, 32'h50, 1'b1, took);
    checkOutput("resume_w16.taken", 64'(took), 64'h1);
    streamWords("resume", 32'h51, N - 1, 1'b1, 1'b0);
    idle("hold_drain", 2);

    // Upper word bits are ignored.
    streamWords("upper", 32'hABCD_EF30, N, 1'b1, 1'b0);
    checkOutput("upper.row_const", row_o, 64'h3733_3632_3531_3430);
    idle("upper_drain", 2);

    // Asynchronous reset with a row pending and a partial row in flight.
    streamWords("pre_reset", 32'h60, N + 5, 1'b0, 1'b0);
    in_valid_i   = 1'b0;
    row_accept_i = 1'b0;
    reset_i      = 1'b1;
    #2;
    checkOutput("async_reset.valid", 64'(row_valid_o), 64'h0);
    checkOutput("async_reset.stall", 64'(upstream_stall_o), 64'h0);
    checkOutput("async_reset.row", row_o, 64'h0);
    checkOutput("async_reset.last", 64'(row_last_o), 64'h0);
    sb.delete();
    word_k  = 0;
    img_row = 0;
    partial = '0;
    #4;
    reset_i = 1'b0;
    @(posedge clock_i);
    #1;
    streamWords("post_reset", 32'h70, N, 1'b1, 1'b0);
    checkOutput("post_reset.row_const", row_o, 64'h7773_7672_7571_7470);
    checkOutput("post_reset.last_const", 64'(row_last_o), 64'h0);
    idle("post_reset_drain", 2);

    // Input valid toggling every other cycle.
    streamWords("toggle", 32'h80, N, 1'b1, 1'b1);
    checkOutput("toggle.valid_const", 64'(row_valid_o), 64'h1);
    checkOutput("toggle.row_const", row_o, 64'h8783_8682_8581_8480);
    idle("toggle_drain", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
